// File: rtl/result_byte_sender_if.sv
// ============================================================================
// Module : result_byte_sender_if
// Brief  : Byte-wise strobe/acknowledge bus between a result sender and its consumer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface result_byte_sender_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic             carry;
  logic             ack;
  logic [7:0]       out;
  logic             strb;
  logic [2:0]       idx;
  logic             busy;
  logic             done;

  modport master (
    output start, data, carry, ack,
    input  out, strb, idx, busy, done
  );

  modport slave (
    input  start, data, carry, ack,
    output out, strb, idx, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/result_byte_sender.sv
// ============================================================================
// Module : result_byte_sender
// Brief  : Captures {carry, data} and sends it LSB byte first over a four-phase
//          strb/ack handshake, optionally followed by a carry byte.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module result_byte_sender #(
  parameter int WIDTH      = 32,
  parameter int SEND_CARRY = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  result_byte_sender_if.slave   bus
);

  localparam int       c_NDATA  = WIDTH / 8;
  localparam int       c_NBYTES = c_NDATA + SEND_CARRY;
  localparam logic [2:0] c_LAST = 3'(c_NBYTES - 1);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_PRESENT = 2'd1;
  localparam logic [1:0] c_RELEASE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic             r_carry;
  logic [7:0]       r_out;
  logic             r_strb;
  logic [2:0]       r_idx;
  logic             r_busy;
  logic             r_done;

  logic [7:0]       w_out_nxt;
  logic             w_strb_nxt;
  logic [2:0]       w_idx_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_capture;
  logic [2:0]       w_idx_inc;
  logic [7:0]       w_bytes [8];

  // Byte lanes of the shadow copy; slots past the last byte read as zero.
  for (genvar k = 0; k < 8; k++) begin : g_bytes
    if (k < c_NDATA) begin : g_data
      assign w_bytes[k] = r_data[8*k +: 8];
    end else if (k == c_NDATA) begin : g_carry
      assign w_bytes[k] = {7'b0, r_carry};
    end else begin : g_pad
      assign w_bytes[k] = 8'h00;
    end
  end

  assign w_idx_inc = r_idx + 3'd1;
  assign w_capture = (r_state == c_IDLE) && bus.start && !bus.ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_data  <= '0;
      r_carry <= 1'b0;
      r_out   <= 8'h00;
      r_strb  <= 1'b0;
      r_idx   <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_strb  <= w_strb_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      if (w_capture) begin
        r_data  <= bus.data;
        r_carry <= bus.carry;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:    if (w_capture) w_state_nxt = c_PRESENT;
      c_PRESENT: if (bus.ack) w_state_nxt = c_RELEASE;
      c_RELEASE: if (!bus.ack) w_state_nxt = (r_idx == c_LAST) ? c_IDLE : c_PRESENT;
      default:   w_state_nxt = c_IDLE;
    endcase
  end

  // Next values of the registered outputs; out/idx hold unless a new byte is loaded.
  always_comb begin
    w_out_nxt  = r_out;
    w_strb_nxt = r_strb;
    w_idx_nxt  = r_idx;
    w_busy_nxt = r_busy;
    w_done_nxt = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_capture) begin
          w_out_nxt  = bus.data[7:0];
          w_idx_nxt  = 3'd0;
          w_strb_nxt = 1'b1;
          w_busy_nxt = 1'b1;
        end
      end
      c_PRESENT: begin
        if (bus.ack) w_strb_nxt = 1'b0;
      end
      c_RELEASE: begin
        if (!bus.ack) begin
          if (r_idx == c_LAST) begin
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b1;
          end else begin
            w_idx_nxt  = w_idx_inc;
            w_out_nxt  = w_bytes[w_idx_inc];
            w_strb_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_strb_nxt = 1'b0;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign bus.out  = r_out;
  assign bus.strb = r_strb;
  assign bus.idx  = r_idx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_result_byte_sender.sv
// ============================================================================
// Module : tb_result_byte_sender
// Brief  : Self-checking bench for result_byte_sender (32-bit+carry and 16-bit).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_result_byte_sender;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  result_byte_sender_if #(.WIDTH(32)) if32 ();
  result_byte_sender_if #(.WIDTH(16)) if16 ();

  result_byte_sender #(.WIDTH(32), .SEND_CARRY(1)) u32 (.clk(clk), .rst(rst), .bus(if32.slave));
  result_byte_sender #(.WIDTH(16), .SEND_CARRY(0)) u16 (.clk(clk), .rst(rst), .bus(if16.slave));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst;
    logic        start;
    logic        ack;
    logic [31:0] data;
    logic        carry;
    logic [7:0]  out;
    logic        strb;
    logic [2:0]  idx;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tv[21];
  logic [7:0] exp_b[$];
  logic [7:0] got_b[$];
  logic [2:0] got_i[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic a, input logic [7:0] o,
                              input logic st, input logic [2:0] ix, input logic b, input logic d);
    vec_t v;
    v.rst = r; v.start = s; v.ack = a; v.data = 32'h89AB_CDEF; v.carry = 1'b1;
    v.out = o; v.strb = st; v.idx = ix; v.busy = b; v.done = d;
    return v;
  endfunction

  function automatic logic get_strb(input bit sel);
    return sel ? if16.strb : if32.strb;
  endfunction

  // Consumer: raises ack 2 cycles after strb, drops it 1 cycle after strb falls
  // (or hold_len cycles when on byte hold_idx). Called at the negedge after strb rose.
  task automatic consume(input bit sel, input int hold_idx, input int hold_len,
                         input bit interfere, input bit b2b, input logic [15:0] b2b_data,
                         output int ndone);
    int   cnt = 0;
    int   rel = 0;
    bit   fin = 0;
    logic pstrb = 1'b0;
    logic s, a, d;
    logic [7:0] o;
    logic [2:0] ix;
    ndone = 0;
    got_b.delete();
    got_i.delete();
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (sel) begin
        if16.start = 1'b0; s = if16.strb; a = if16.ack; d = if16.done; o = if16.out; ix = if16.idx;
      end else begin
        if32.start = 1'b0; s = if32.strb; a = if32.ack; d = if32.done; o = if32.out; ix = if32.idx;
      end
      if (s && !pstrb) chk("strb_rise_ack_low", {31'b0, a}, 32'd0);
      if (s && (int'(ix) < exp_b.size())) chk("out_matches_idx", {24'b0, o}, {24'b0, exp_b[ix]});
      if (d) begin
        ndone++;
        fin = 1;
        if (b2b) begin
          if16.start = 1'b1;
          if16.data  = b2b_data;
        end
      end else if (s && !a) begin
        cnt++;
        if (interfere && !sel && ix == 3'd1 && cnt == 1) begin
          if32.start = 1'b1;
          if32.data  = 32'h0;
          if32.carry = 1'b0;
        end
        if (cnt == 2) begin
          got_b.push_back(o);
          got_i.push_back(ix);
          cnt = 0;
          if (sel) if16.ack = 1'b1; else if32.ack = 1'b1;
        end
      end else if (!s && a) begin
        rel++;
        if (rel >= ((int'(ix) == hold_idx) ? hold_len : 1)) begin
          rel = 0;
          if (sel) if16.ack = 1'b0; else if32.ack = 1'b0;
        end
      end
      pstrb = s;
      @(negedge clk);
    end
    if (!fin) chk("consume_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_seq(input string name);
    chk({name, "_nbytes"}, got_b.size(), exp_b.size());
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
      chk({name, "_byte"}, {24'b0, got_b[i]}, {24'b0, exp_b[i]});
      chk({name, "_idx"}, {29'b0, got_i[i]}, i);
    end
  endtask

  initial begin
    int nd;
    if32.start = 1'b0; if32.ack = 1'b0; if32.data = 32'h0; if32.carry = 1'b0;
    if16.start = 1'b0; if16.ack = 1'b0; if16.data = 16'h0; if16.carry = 1'b0;

    //         rst start ack  out   strb idx busy done
    tv[0]  = mk(1, 0, 0, 8'h00, 0, 0, 0, 0);
    tv[1]  = mk(1, 0, 0, 8'h00, 0, 0, 0, 0);
    tv[2]  = mk(0, 1, 0, 8'hEF, 1, 0, 1, 0);
    tv[3]  = mk(0, 0, 0, 8'hEF, 1, 0, 1, 0);
    tv[4]  = mk(0, 0, 1, 8'hEF, 0, 0, 1, 0);
    tv[5]  = mk(0, 0, 0, 8'hCD, 1, 1, 1, 0);
    tv[6]  = mk(0, 0, 0, 8'hCD, 1, 1, 1, 0);
    tv[7]  = mk(0, 0, 1, 8'hCD, 0, 1, 1, 0);
    tv[8]  = mk(0, 0, 0, 8'hAB, 1, 2, 1, 0);
    tv[9]  = mk(0, 0, 0, 8'hAB, 1, 2, 1, 0);
    tv[10] = mk(0, 0, 1, 8'hAB, 0, 2, 1, 0);
    tv[11] = mk(0, 0, 0, 8'h89, 1, 3, 1, 0);
    tv[12] = mk(0, 0, 0, 8'h89, 1, 3, 1, 0);
    tv[13] = mk(0, 0, 1, 8'h89, 0, 3, 1, 0);
    tv[14] = mk(0, 0, 0, 8'h01, 1, 4, 1, 0);
    tv[15] = mk(0, 0, 0, 8'h01, 1, 4, 1, 0);
    tv[16] = mk(0, 0, 1, 8'h01, 0, 4, 1, 0);
    tv[17] = mk(0, 0, 0, 8'h01, 0, 4, 0, 1);
    tv[18] = mk(0, 0, 1, 8'h01, 0, 4, 0, 0);
    tv[19] = mk(0, 1, 1, 8'h01, 0, 4, 0, 0);
    tv[20] = mk(0, 1, 0, 8'hEF, 1, 0, 1, 0);

    for (int i = 0; i < 21; i++) begin
      rst = tv[i].rst; if32.start = tv[i].start; if32.ack = tv[i].ack;
      if32.data = tv[i].data; if32.carry = tv[i].carry;
      @(negedge clk);
      chk($sformatf("v%0d_out", i),  {24'b0, if32.out},  {24'b0, tv[i].out});
      chk($sformatf("v%0d_strb", i), {31'b0, if32.strb}, {31'b0, tv[i].strb});
      chk($sformatf("v%0d_idx", i),  {29'b0, if32.idx},  {29'b0, tv[i].idx});
      chk($sformatf("v%0d_busy", i), {31'b0, if32.busy}, {31'b0, tv[i].busy});
      chk($sformatf("v%0d_done", i), {31'b0, if32.done}, {31'b0, tv[i].done});
    end
    chk("idle16_busy", {31'b0, if16.busy}, 32'd0);

    // Interference: restart attempt + data change on byte 1, ack held 10 cycles there.
    if32.start = 1'b0;
    exp_b = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h01};
    consume(1'b0, 1, 10, 1'b1, 1'b0, 16'h0, nd);
    check_seq("interfere");
    chk("interfere_done_pulses", nd, 1);
    chk("interfere_done_fall", {31'b0, if32.done}, 32'd0);
    chk("interfere_busy_after", {31'b0, if32.busy}, 32'd0);

    // Reset while presenting byte 2.
    if32.data = 32'hA5A5_5A5A; if32.carry = 1'b0; if32.start = 1'b1;
    @(negedge clk);
    if32.start = 1'b0;
    chk("rst_seq_byte0", {24'b0, if32.out}, 32'h5A);
    for (int i = 0; i < 2; i++) begin
      if32.ack = 1'b1; @(negedge clk);
      if32.ack = 1'b0; @(negedge clk);
    end
    chk("rst_seq_idx2", {29'b0, if32.idx}, 32'd2);
    chk("rst_seq_out2", {24'b0, if32.out}, 32'hA5);
    chk("rst_seq_strb2", {31'b0, if32.strb}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_strb", {31'b0, if32.strb}, 32'd0);
    chk("midrst_busy", {31'b0, if32.busy}, 32'd0);
    chk("midrst_out",  {24'b0, if32.out},  32'd0);
    chk("midrst_idx",  {29'b0, if32.idx},  32'd0);
    chk("midrst_done", {31'b0, if32.done}, 32'd0);
    @(negedge clk);
    chk("midrst_no_done", {31'b0, if32.done}, 32'd0);

    if32.data = 32'h1122_3344; if32.carry = 1'b0; if32.start = 1'b1;
    @(negedge clk);
    if32.start = 1'b0;
    exp_b = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
    consume(1'b0, -1, 1, 1'b0, 1'b0, 16'h0, nd);
    check_seq("after_rst");
    chk("after_rst_done_pulses", nd, 1);

    // 16-bit, no carry byte, back-to-back start on the done cycle.
    if16.data = 16'h1234; if16.carry = 1'b1; if16.start = 1'b1;
    @(negedge clk);
    if16.start = 1'b0;
    exp_b = '{8'h34, 8'h12};
    consume(1'b1, -1, 1, 1'b0, 1'b1, 16'h5678, nd);
    if16.start = 1'b0;
    check_seq("w16");
    chk("w16_done_pulses", nd, 1);
    chk("b2b_strb", {31'b0, if16.strb}, 32'd1);
    chk("b2b_busy", {31'b0, if16.busy}, 32'd1);
    chk("b2b_out",  {24'b0, if16.out},  32'h78);
    chk("b2b_idx",  {29'b0, if16.idx},  32'd0);
    chk("b2b_done", {31'b0, if16.done}, 32'd0);
    exp_b = '{8'h78, 8'h56};
    consume(1'b1, -1, 1, 1'b0, 1'b0, 16'h0, nd);
    check_seq("b2b");
    chk("b2b_done_pulses", nd, 1);
    chk("b2b_busy_after", {31'b0, if16.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
